// File: rtl/mem_wait_unit.sv
// mem_wait_unit: unified instruction/data memory with a fixed-latency wait-state
// controller. Requests are latched on acceptance, completed LATENCY+1 cycles
// later with a one-cycle ready pulse, and counted in acc_cnt.
module mem_wait_unit #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              init,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              err,
    output logic [15:0]       acc_cnt
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned WAIT_W = 4;
    localparam int unsigned ACC_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                op_wr_q, op_wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                mem_we;
    logic                req_one;
    logic                req_both;

    logic [DATA_W-1:0]   mem [DEPTH];

    assign req_one  = mem_read ^ mem_write;
    assign req_both = mem_read & mem_write;

    // State register
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept one-hot requests, count down the wait, single DONE cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_one) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output/datapath logic: request latch, wait counter, completion side effects
    always_comb begin
        wait_d  = wait_q;
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        busy_d  = (state_d == ST_WAIT);
        err_d   = 1'b0;
        acc_d   = acc_q;
        mem_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_one) begin
                    op_wr_d = mem_write;
                    addr_d  = addr;
                    wdata_d = wdata;
                    wait_d  = WAIT_W'(LATENCY - 1);
                end else if (req_both) begin
                    err_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            ST_DONE: begin
                ready_d = 1'b1;
                acc_d   = acc_q + ACC_W'(1);
                if (op_wr_q) begin
                    // A reset arriving on the commit edge must suppress the write.
                    mem_we = ~init;
                end else begin
                    rdata_d = mem[addr_q];
                end
            end
            default: begin
                wait_d = '0;
            end
        endcase
    end

    // Registered outputs, request latch and counters
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            wait_q  <= '0;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            acc_q   <= '0;
        end else begin
            wait_q  <= wait_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            acc_q   <= acc_d;
        end
    end

    // Memory array write port; contents are not reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign rdata   = rdata_q;
    assign ready   = ready_q;
    assign busy    = busy_q;
    assign err     = err_q;
    assign acc_cnt = acc_q;

endmodule

// File: tb/tb_mem_wait_unit.sv
// Bench for mem_wait_unit: a LATENCY=2 instance and a LATENCY=1 instance share
// the same stimulus; expected completions are queued at issue and checked at ready.
module tb_mem_wait_unit;

    logic        clk = 1'b0;
    logic        init;
    logic        mem_read;
    logic        mem_write;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata, rdata1;
    logic        ready, ready1;
    logic        busy, busy1;
    logic        err, err1;
    logic [15:0] acc_cnt, acc_cnt1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          is_read;
        logic [15:0] data;
        logic [15:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] model_mem [int];
    logic [15:0] model_cnt;
    logic [15:0] model_rdata;

    always #5 clk = ~clk;

    mem_wait_unit #(.ADDR_W(12), .DATA_W(16), .LATENCY(2)) dut (
        .clk(clk), .init(init), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
        .busy(busy), .err(err), .acc_cnt(acc_cnt)
    );

    mem_wait_unit #(.ADDR_W(12), .DATA_W(16), .LATENCY(1)) dut1 (
        .clk(clk), .init(init), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .rdata(rdata1), .ready(ready1),
        .busy(busy1), .err(err1), .acc_cnt(acc_cnt1)
    );

    // Issue one access at a negedge (DUTs idle), scramble inputs during WAIT,
    // then check the completion against the queued expectation. Ends on a negedge.
    task automatic do_access(input bit rd, input logic [11:0] a, input logic [15:0] d,
                             input logic [11:0] alt_a);
        exp_t e;
        int   n;
        int   n1;
        int   busy_n;
        bit   got;
        e.is_read = rd;
        e.data    = 16'h0000;
        if (rd) begin
            e.data      = model_mem[int'(a)];
            model_rdata = e.data;
        end else begin
            model_mem[int'(a)] = d;
        end
        model_cnt = model_cnt + 16'd1;
        e.cnt     = model_cnt;
        exp_q.push_back(e);

        mem_read  = rd;
        mem_write = !rd;
        addr      = a;
        wdata     = d;
        @(posedge clk);
        @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = alt_a;
        wdata     = ~d;

        n = 0; n1 = -1; busy_n = 0; got = 1'b0;
        while (!got && n < 20) begin
            if (busy === 1'b1) busy_n++;
            if (ready1 === 1'b1 && n1 < 0) n1 = n;
            total++;
            if (err !== 1'b0 || err1 !== 1'b0) begin
                bad++;
                $display("FAIL err_during_access addr=%h err=%b err1=%b expected 0", a, err, err1);
            end
            if (ready === 1'b1) got = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end

        total++;
        if (!got) begin
            bad++;
            $display("FAIL ready_timeout addr=%h no ready within 20 cycles", a);
            void'(exp_q.pop_front());
        end else begin
            e = exp_q.pop_front();
            if (n !== 3) begin
                bad++;
                $display("FAIL latency_l2 addr=%h got=%0d expected=3", a, n);
            end
            total++;
            if (busy_n !== 2) begin
                bad++;
                $display("FAIL busy_cycles addr=%h got=%0d expected=2", a, busy_n);
            end
            total++;
            if (n1 !== 2) begin
                bad++;
                $display("FAIL latency_l1 addr=%h got=%0d expected=2", a, n1);
            end
            total++;
            if (acc_cnt !== e.cnt || acc_cnt1 !== e.cnt) begin
                bad++;
                $display("FAIL acc_cnt addr=%h got=%h/%h expected=%h", a, acc_cnt, acc_cnt1, e.cnt);
            end
            total++;
            if (e.is_read) begin
                if (rdata !== e.data || rdata1 !== e.data) begin
                    bad++;
                    $display("FAIL read_data addr=%h got=%h/%h expected=%h", a, rdata, rdata1, e.data);
                end
            end else begin
                if (rdata !== model_rdata || rdata1 !== model_rdata) begin
                    bad++;
                    $display("FAIL rdata_on_write addr=%h got=%h/%h expected=%h", a, rdata, rdata1, model_rdata);
                end
            end
        end
    endtask

    task automatic test_reset();
        init = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
        model_cnt = 16'h0000;
        model_rdata = 16'h0000;
        repeat (3) @(negedge clk);
        total++;
        if (rdata !== 16'h0000) begin bad++; $display("FAIL reset_rdata got=%h expected=0000", rdata); end
        total++;
        if (ready !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            bad++; $display("FAIL reset_flags got=%b%b%b expected=000", ready, busy, err);
        end
        total++;
        if (acc_cnt !== 16'h0000) begin bad++; $display("FAIL reset_acc got=%h expected=0000", acc_cnt); end
        total++;
        if ({rdata1, acc_cnt1, ready1, busy1, err1} !== 35'h0) begin
            bad++; $display("FAIL reset_l1 got=%h/%h/%b%b%b expected zeros", rdata1, acc_cnt1, ready1, busy1, err1);
        end
        init = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        do_access(1'b0, 12'h010, 16'hBEEF, 12'h000);
        do_access(1'b1, 12'h010, 16'h0000, 12'h000);
        @(negedge clk);
        total++;
        if (ready !== 1'b0 || rdata !== 16'hBEEF) begin
            bad++; $display("FAIL rdata_hold got=%h ready=%b expected=BEEF ready=0", rdata, ready);
        end
    endtask

    task automatic test_latch();
        do_access(1'b0, 12'h020, 16'hA5A5, 12'h010);
        do_access(1'b1, 12'h020, 16'h0000, 12'h010);
    endtask

    task automatic test_err();
        mem_read = 1'b1; mem_write = 1'b1; addr = 12'h010; wdata = 16'h1111;
        @(posedge clk);
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0;
        total++;
        if (err !== 1'b1 || err1 !== 1'b1) begin bad++; $display("FAIL err_pulse got=%b/%b expected=1", err, err1); end
        total++;
        if (ready !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL err_side ready=%b busy=%b expected=0 0", ready, busy);
        end
        @(negedge clk);
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL err_one_cycle got=%b expected=0", err); end
        total++;
        if (acc_cnt !== model_cnt || rdata !== model_rdata) begin
            bad++; $display("FAIL err_no_access acc=%h rdata=%h expected=%h %h", acc_cnt, rdata, model_cnt, model_rdata);
        end
    endtask

    task automatic test_back_to_back();
        do_access(1'b0, 12'h040, 16'h7777, 12'h041);
        do_access(1'b1, 12'h040, 16'h0000, 12'h041);
        do_access(1'b0, 12'hFFF, 16'h0F0F, 12'h000);
        do_access(1'b1, 12'hFFF, 16'h0000, 12'h000);
    endtask

    task automatic test_abort();
        bit seen;
        do_access(1'b0, 12'h030, 16'h5555, 12'h000);
        mem_write = 1'b1; addr = 12'h030; wdata = 16'h1234;
        @(posedge clk);
        @(negedge clk);
        mem_write = 1'b0;
        @(negedge clk);
        init = 1'b1;
        #1;
        total++;
        if ({rdata, ready, busy, err, acc_cnt} !== 35'h0) begin
            bad++; $display("FAIL abort_outputs rdata=%h flags=%b%b%b acc=%h expected zeros", rdata, ready, busy, err, acc_cnt);
        end
        total++;
        if ({rdata1, ready1, busy1, err1, acc_cnt1} !== 35'h0) begin
            bad++; $display("FAIL abort_outputs_l1 rdata=%h flags=%b%b%b acc=%h expected zeros", rdata1, ready1, busy1, err1, acc_cnt1);
        end
        @(negedge clk);
        init = 1'b0;
        model_cnt = 16'h0000;
        model_rdata = 16'h0000;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ready === 1'b1 || ready1 === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen) begin bad++; $display("FAIL abort_ready got=1 expected no ready after abort"); end
        do_access(1'b1, 12'h030, 16'h0000, 12'h010);
    endtask

    task automatic test_wrap();
        force dut.acc_q = 16'hFFFF;
        force dut1.acc_q = 16'hFFFF;
        @(negedge clk);
        release dut.acc_q;
        release dut1.acc_q;
        @(negedge clk);
        total++;
        if (acc_cnt !== 16'hFFFF || acc_cnt1 !== 16'hFFFF) begin
            bad++; $display("FAIL preload_acc got=%h/%h expected=FFFF", acc_cnt, acc_cnt1);
        end
        model_cnt = 16'hFFFF;
        do_access(1'b1, 12'h010, 16'h0000, 12'h020);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_latch();
        test_err();
        test_back_to_back();
        test_abort();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_wait_unit.md
Name: mem_wait_unit

Overview:
- Unified 16-bit instruction/data memory with a wait-state controller.
- Sits directly downstream of the multicycle MIPS datapath and consumes its memRead/memWrite/address/write-data outputs.
- Returns read data together with a one-cycle ready pulse after a fixed, parameterised latency, so the control unit can stall in its memory states until ready.
- Latches the request on acceptance, so the datapath need not hold the address stable during the wait.

Parameters:
- ADDR_W, 12, word-address width; the array holds 2**ADDR_W words.
- DATA_W, 16, word width; matches the 16-bit instruction format.
- LATENCY, 2, wait cycles between acceptance and completion; legal range 1..15.

Ports:
- clk  in  1  system clock; rising edge active.
- init  in  1  asynchronous active-high reset.
- mem_read  in  1  read request level.
- mem_write  in  1  write request level.
- addr  in  ADDR_W  word address.
- wdata  in  DATA_W  write data.
- rdata  out  DATA_W  read data; valid in the ready cycle of a read and held until the next read completes.
- ready  out  1  one-cycle pulse marking completion of a read or write.
- busy  out  1  high while a request is in flight (WAIT state).
- err  out  1  one-cycle pulse on an illegal request.
- acc_cnt  out  16  count of completed accesses; wraps 0xFFFF -> 0x0000.

Behaviour:
- Reset: clk and init are the only clock/reset; init is asynchronous and active-high.
  - On init: state = IDLE, rdata = 0, ready = 0, busy = 0, err = 0, acc_cnt = 0, wait counter = 0, latched request cleared.
  - Array contents are not reset.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - Exactly one of mem_read/mem_write high: latch addr, wdata and op; load counter = LATENCY-1; go to WAIT.
  - Both high: err pulses next cycle, no access, stay in IDLE.
  - Neither high: stay in IDLE.
- WAIT:
  - busy = 1.
  - Counter decrements each cycle; at 0, go to DONE.
  - Input changes during WAIT are ignored; the latched request is used.
- DONE (one cycle):
  - ready = 1.
  - Read: rdata <= mem[latched addr], registered so it is visible in the same cycle ready is high.
  - Write: mem[latched addr] <= latched wdata at the DONE edge.
  - acc_cnt increments.
  - Next state is IDLE unconditionally. A request still asserted in IDLE is accepted as a new access, so the CU must deassert in the cycle after ready.
- Timing: acceptance edge to ready high is LATENCY+1 cycles; back-to-back accesses issue every LATENCY+2 cycles.
- Read-after-write to the same address in the following access returns the new data; there is no bypass hazard, since the write commits before the next acceptance.
- Address wrap: addr is a full ADDR_W field; there is no out-of-range condition.
- Reset mid-operation (init in WAIT or DONE): access aborted, a write is not committed (if init coincides with the DONE edge, init wins), ready stays 0, acc_cnt = 0.
- err and ready are never high in the same cycle.
- rdata is unchanged by writes and by error cycles.

Test Plan:
- Reset, then write 0xBEEF to addr 0x010 with LATENCY=2 -> busy high 2 cycles, ready pulses 3 cycles after acceptance, acc_cnt = 1.
- Read addr 0x010 -> ready pulse with rdata = 0xBEEF; rdata holds 0xBEEF afterwards; acc_cnt = 2.
- Read addr 0x020 and change addr to 0x010 during WAIT -> rdata = mem[0x020], proving the request was latched.
- mem_read and mem_write both high in IDLE -> err pulses one cycle, ready stays 0, busy stays 0, acc_cnt unchanged.
- Start a write of 0x1234 to addr 0x030, assert init during WAIT -> outputs return to reset values, and a subsequent read of 0x030 does not return 0x1234.
- Preload acc_cnt to 0xFFFF via 65535 accesses (or a forced count), then one more read -> acc_cnt = 0x0000; LATENCY=1 build gives ready 2 cycles after acceptance.
